// File: rtl/vect_pkg.sv
// Vector-lane shared definitions: opcode constants, opcode classification,
// and the element-sequencer state encoding.
package vect_pkg;

  localparam int OPC_W = 7;
  typedef logic [OPC_W-1:0] op_t;

  // Opcodes are {funct[4:0], class[1:0]}.
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_DIV = 2'b10;

  localparam op_t VADD   = {5'd0, CLS_ALU};
  localparam op_t VSUB   = {5'd1, CLS_ALU};
  localparam op_t VAND   = {5'd2, CLS_ALU};
  localparam op_t VOR    = {5'd3, CLS_ALU};
  localparam op_t VXOR   = {5'd4, CLS_ALU};
  localparam op_t VMUL   = {5'd0, CLS_MUL};
  localparam op_t VMULH  = {5'd1, CLS_MUL};
  localparam op_t VMACC  = {5'd2, CLS_MUL};
  localparam op_t VMADD  = {5'd3, CLS_MUL};
  localparam op_t VNMSAC = {5'd4, CLS_MUL};
  localparam op_t VNMSUB = {5'd5, CLS_MUL};
  localparam op_t VDIV   = {5'd0, CLS_DIV};
  localparam op_t VDIVU  = {5'd1, CLS_DIV};
  localparam op_t VREM   = {5'd2, CLS_DIV};

  typedef enum logic [1:0] {OPC_ALU, OPC_MUL, OPC_DIV} op_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} seq_state_e;

  // Unknown opcodes fall through to the single-cycle ALU path.
  function automatic op_class_e op_class(input op_t op);
    case (op)
      VMUL, VMULH, VMACC, VMADD, VNMSAC, VNMSUB: op_class = OPC_MUL;
      VDIV, VDIVU, VREM:                         op_class = OPC_DIV;
      default:                                   op_class = OPC_ALU;
    endcase
  endfunction

  // Multiply-accumulate ops read their accumulator at the write-back index.
  function automatic logic is_macc(input op_t op);
    return op inside {VMACC, VMADD, VNMSAC, VNMSUB};
  endfunction

endpackage

// File: rtl/alu_elem_sequencer_mul_tag_pipe.sv
// Enabled shift register of {valid, idx} tags that travels in lockstep with
// the multiplier pipe, so each multiply result emerges with its destination.
module mul_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             tail_empty_o
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  // Shift one stage per enabled cycle; reset and flush drop every tag.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
      // NOTE: the index array is cleared as well as the valid bits so a
      // flushed pipe never shows a stale index on its outputs.
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else if (en_i) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // old value, giving a true shift regardless of statement order.
      vld_q[0] <= in_valid_i;
      idx_q[0] <= in_idx_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_idx_o   = idx_q[DEPTH-1];

  // No valid tag behind the output stage: the pipe is empty after the next shift.
  always_comb begin
    tail_empty_o = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (vld_q[i]) tail_empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_elem_sequencer.sv
// Per-lane element sequencer: steps one vector instruction through the ALU
// or the pipelined multiplier and produces the write-back handshake.
module alu_elem_sequencer
  import vect_pkg::*;
#(
  parameter int PIPE_ST = 5,
  parameter int VL_W    = 6,
  parameter int OP_W    = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [OP_W-1:0] instr_op_i,
  input  logic [VL_W:0]   instr_vl_i,
  input  logic            instr_masked_i,
  input  logic            mask_bit_i,
  output logic [VL_W-1:0] elem_idx_o,
  output logic            alu_valid_o,
  output logic            alu_mask_en_o,
  output logic [OP_W-1:0] alu_op_o,
  output logic            mul_en_o,
  output logic            wb_valid_o,
  output logic [VL_W-1:0] wb_idx_o,
  input  logic            wb_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [VL_W:0]   ONE_VL  = 1;
  localparam logic [VL_W-1:0] ONE_IDX = 1;

  seq_state_e      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [VL_W:0]   vl_q, vl_d;
  logic            masked_q, masked_d;
  logic [VL_W-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            is_mul, mask_en, last_elem, stall, accept, done_now;
  logic            wb_valid, tag_in_valid, tag_out_valid, tag_tail_empty;
  logic [VL_W-1:0] wb_idx, tag_out_idx;

  assign is_mul    = (op_class(op_q) == OPC_MUL);
  assign mask_en   = ~masked_q | mask_bit_i;
  assign last_elem = ({1'b0, idx_q} == (vl_q - ONE_VL));

  // Write-back source: tag pipe output for multiplies, the issuing element for ALU ops.
  always_comb begin
    wb_valid = 1'b0;
    wb_idx   = '0;
    if (is_mul && state_q != ST_IDLE) begin
      wb_valid = tag_out_valid;
      wb_idx   = tag_out_valid ? tag_out_idx : '0;
    end else if (!is_mul && state_q == ST_ISSUE) begin
      wb_valid = mask_en;
      wb_idx   = mask_en ? idx_q : '0;
    end
  end

  assign stall        = wb_valid & ~wb_ready_i;
  assign mul_en_o     = is_mul & (state_q != ST_IDLE) & ~stall;
  assign tag_in_valid = (state_q == ST_ISSUE) & mask_en;
  assign accept       = instr_valid_i & instr_ready_o;

  mul_tag_pipe #(
    .DEPTH (PIPE_ST - 1),
    .IDX_W (VL_W)
  ) u_tag_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (accept),
    .en_i         (mul_en_o),
    .in_valid_i   (tag_in_valid),
    .in_idx_i     (idx_q),
    .out_valid_o  (tag_out_valid),
    .out_idx_o    (tag_out_idx),
    .tail_empty_o (tag_tail_empty)
  );

  // Next-state and control outputs; everything holds while stalled.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    vl_d          = vl_q;
    masked_d      = masked_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    done_now      = 1'b0;
    instr_ready_o = 1'b0;
    alu_valid_o   = 1'b0;
    alu_mask_en_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          op_d     = instr_op_i;
          vl_d     = instr_vl_i;
          masked_d = instr_masked_i;
          idx_d    = '0;
          // An unsupported opcode is rejected even when vl is zero.
          if (op_class(instr_op_i) == OPC_DIV) err_d = 1'b1;
          else if (instr_vl_i == '0)           done_d = 1'b1;
          else                                 state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_valid_o   = 1'b1;
        alu_mask_en_o = mask_en;
        if (!stall) begin
          if (!last_elem) begin
            idx_d = idx_q + ONE_IDX;
          end else if (is_mul) begin
            state_d = ST_DRAIN;
          end else begin
            state_d  = ST_IDLE;
            done_now = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Hold the ALU select on the multiply result while it is written back.
        alu_valid_o   = wb_valid;
        alu_mask_en_o = wb_valid;
        if (!stall && tag_tail_empty) begin
          state_d  = ST_IDLE;
          done_now = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-instruction registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      vl_q     <= '0;
      masked_q <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vl_q     <= vl_d;
      masked_q <= masked_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign elem_idx_o = idx_q;
  assign alu_op_o   = op_q;
  assign wb_valid_o = wb_valid;
  assign wb_idx_o   = wb_idx;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q | done_now;
  assign err_o      = err_q;

endmodule
